// File: rtl/adaptive_threshold.sv
// Adaptive binary threshold: streams the source image and local-mean memories in raster
// order and writes 255 where pixel > (mean - C), else 0, through a 3-stage pipeline.
module adaptive_threshold #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int WIDTH       = 2**WIDTH_BITS,
    parameter int HEIGHT      = 2**HEIGHT_BITS
) (
    input  logic                   clock,
    input  logic                   not_reset,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oMeanCol,
    output logic [HEIGHT_BITS-1:0] oMeanRow,
    input  logic [7:0]             iMeanData,
    input  logic [7:0]             iOffset,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    output logic [7:0]             oResultData,
    output logic                   oResultWren,
    input  logic [2:0]             global_state,
    output logic                   finished
);
    localparam int PW = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [PW-1:0] LAST_POS = PW'(WIDTH * HEIGHT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [PW-1:0] r_pos;
    logic [PW-1:0] r_pos1;
    logic          r_v1;
    logic [PW-1:0] r_rpos;
    logic [7:0]    r_rdata;
    logic          r_wren;
    logic          r_finished;
    logic          r_fresh;
    logic [7:0]    r_pix_hold;
    logic [7:0]    r_mean_hold;

    logic              w_run;
    logic              w_active;
    logic [7:0]        w_pix;
    logic [7:0]        w_mean;
    logic signed [9:0] w_thresh;
    logic              w_white;

    assign w_run    = (global_state == 3'd2);
    assign w_active = w_run && ((r_state == RUN) || (r_state == DRAIN));

    // While paused the RAMs already read the next address, so the stage-1 operands are
    // taken from a copy captured on the first paused cycle when the pipeline resumes.
    assign w_pix    = r_fresh ? iImageData : r_pix_hold;
    assign w_mean   = r_fresh ? iMeanData  : r_mean_hold;
    assign w_thresh = $signed({2'b00, w_mean}) - $signed({2'b00, iOffset});
    assign w_white  = $signed({2'b00, w_pix}) > w_thresh;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            r_state     <= IDLE;
            r_pos       <= '0;
            r_pos1      <= '0;
            r_v1        <= 1'b0;
            r_rpos      <= '0;
            r_rdata     <= '0;
            r_wren      <= 1'b0;
            r_finished  <= 1'b0;
            r_fresh     <= 1'b0;
            r_pix_hold  <= '0;
            r_mean_hold <= '0;
        end else begin
            r_fresh <= w_active;
            if (r_fresh) begin
                r_pix_hold  <= iImageData;
                r_mean_hold <= iMeanData;
            end

            case (r_state)
                IDLE: begin
                    if (w_run)
                        r_state <= RUN;
                end
                RUN: begin
                    if (w_run) begin
                        r_v1   <= 1'b1;
                        r_pos1 <= r_pos;
                        if (r_pos == LAST_POS)
                            r_state <= DRAIN;
                        else
                            r_pos <= r_pos + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_run) begin
                        r_v1 <= 1'b0;
                        if (r_wren && !r_v1) begin
                            r_state    <= DONE;
                            r_finished <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (w_active) begin
                r_wren <= r_v1;
                if (r_v1) begin
                    r_rpos  <= r_pos1;
                    r_rdata <= w_white ? 8'd255 : 8'd0;
                end
            end
        end
    end

    assign oImageCol   = r_pos[WIDTH_BITS-1:0];
    assign oImageRow   = r_pos[PW-1:WIDTH_BITS];
    assign oMeanCol    = r_pos[WIDTH_BITS-1:0];
    assign oMeanRow    = r_pos[PW-1:WIDTH_BITS];
    assign oResultCol  = r_rpos[WIDTH_BITS-1:0];
    assign oResultRow  = r_rpos[PW-1:WIDTH_BITS];
    assign oResultData = r_rdata;
    assign oResultWren = r_wren && w_run;
    assign finished    = r_finished;
endmodule
